// File: rtl/seg7_scan_driver.sv
// Purpose: multiplexed hex seven-segment scan driver with shadow value/dp registers and leading-zero blanking.
// Latency: outputs registered, 1 cycle from index/shadow/blank_lz/enable; load visible after 2 edges.
// Backpressure: none; enable=0 freezes the scan position and drives every output to the unlit level.
module seg7_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic                  enable,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an_out,
    output logic                  frame_tick
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    // Polarity mask: XOR an active-high "lit" vector with this to get pin levels.
    localparam logic                INV        = (ACTIVE_LOW != 0);
    localparam logic [6:0]          SEG_UNLIT  = {7{INV}};
    localparam logic [DIGITS-1:0]   AN_UNLIT   = {DIGITS{INV}};

    logic [4*DIGITS-1:0] value_q;
    logic [DIGITS-1:0]   dp_q;
    logic [PW-1:0]       presc;
    logic [IW-1:0]       idx;
    logic                tick;

    logic [6:0]          seg_on;
    logic                dp_on;
    logic [DIGITS-1:0]   an_on;
    logic [3:0]          nib;
    logic                sel_blank;
    logic                sel_dp;
    logic [DIGITS-1:0]   an_sel;
    logic [DIGITS-1:0]   lz;
    logic                zero_run;

    // Hex glyphs, returned active-high (1 = segment lit), bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_map(input logic [3:0] n);
        logic [6:0] low;
        case (n)
            4'h0: low = 7'h40;
            4'h1: low = 7'h79;
            4'h2: low = 7'h24;
            4'h3: low = 7'h30;
            4'h4: low = 7'h19;
            4'h5: low = 7'h12;
            4'h6: low = 7'h02;
            4'h7: low = 7'h78;
            4'h8: low = 7'h00;
            4'h9: low = 7'h18;
            4'hA: low = 7'h08;
            4'hB: low = 7'h03;
            4'hC: low = 7'h46;
            4'hD: low = 7'h21;
            4'hE: low = 7'h06;
            default: low = 7'h0E;
        endcase
        return ~low;
    endfunction

    // The last prescaler count of a dwell is the scan tick; it only exists while enabled.
    assign tick = enable && (presc == PRESC_LAST);

    // Shadow capture is independent of enable so software can update a frozen display.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
            dp_q    <= '0;
        end else if (load) begin
            value_q <= value;
            dp_q    <= dp_in;
        end
    end

    // Prescaler and digit index advance only while enabled, so re-enabling resumes mid-dwell.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc      <= '0;
            idx        <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= tick && (idx == IDX_LAST);
            if (enable) begin
                presc <= tick ? '0 : presc + PW'(1);
            end
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end
        end
    end

    // Select the current digit and decide blanking: lz[k] is set when nibble k and all above are zero.
    always_comb begin
        zero_run  = 1'b1;
        lz        = '0;
        nib       = 4'h0;
        sel_blank = 1'b0;
        sel_dp    = 1'b0;
        an_sel    = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (value_q[4*k +: 4] == 4'h0);
            lz[k]    = zero_run;
        end
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                nib       = value_q[4*k +: 4];
                sel_blank = blank_lz && (k != 0) && lz[k];
                sel_dp    = dp_q[k];
                an_sel[k] = 1'b1;
            end
        end
        seg_on = (enable && !sel_blank) ? seg_map(nib) : 7'h00;
        dp_on  = enable && sel_dp;
        an_on  = enable ? an_sel : '0;
    end

    // Register the pin levels; reset forces them unlit without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_out <= SEG_UNLIT;
            dp_out  <= INV;
            an_out  <= AN_UNLIT;
        end else begin
            seg_out <= seg_on ^ SEG_UNLIT;
            dp_out  <= dp_on ^ INV;
            an_out  <= an_on ^ AN_UNLIT;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Purpose: randomized + directed scoreboard bench for seg7_scan_driver (DIGITS=4, SCAN_DIV=4, active-low).
// Latency: expected pin state pushed per edge, popped and compared at the following falling edge.
// Backpressure: none; the DUT presents an output every cycle, so the monitor pops once per cycle.
module tb_seg7_scan_driver;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    // Active-low glyph table for 0..F.
    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic        enable;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;

    // Reference model: count of enabled edges since reset plus the shadow contents.
    int          n_en;
    logic [15:0] val_m;
    logic [3:0]  dp_m;

    // Expected {frame_tick, dp, an, seg} after one edge.
    logic [12:0] sb[$];

    seg7_scan_driver #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .ACTIVE_LOW(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .dp_in     (dp_in),
        .load      (load),
        .blank_lz  (blank_lz),
        .enable    (enable),
        .seg_out   (seg_out),
        .dp_out    (dp_out),
        .an_out    (an_out),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] expect_out(input int n, input logic [15:0] v,
                                               input logic [3:0] d, input logic bl,
                                               input logic en);
        int          k;
        logic [15:0] rest;
        logic        blanked;
        logic [6:0]  seg;
        logic [3:0]  one;
        logic        ft;
        if (!en) return {1'b0, 1'b1, 4'hF, 7'h7F};
        k       = (n / SCAN_DIV) % DIGITS;
        rest    = v >> (4 * k);
        blanked = bl && (k != 0) && (rest == 16'h0);
        seg     = blanked ? 7'h7F : SEG_TAB[rest[3:0]];
        one     = 4'b0001;
        ft      = ((n % FRAME) == FRAME - 1);
        return {ft, ~d[k], ~(one << k), seg};
    endfunction

    // Monitor: compare the DUT pins against the oldest pending expectation.
    always @(negedge clk) begin
        logic [12:0] exp_v;
        logic [12:0] act_v;
        if (sb.size() > 0) begin
            exp_v = sb.pop_front();
            act_v = {frame_tick, dp_out, an_out, seg_out};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL scan t=%0t: got ft=%b dp=%b an=%b seg=%h, expected ft=%b dp=%b an=%b seg=%h",
                         $time, act_v[12], act_v[11], act_v[10:7], act_v[6:0],
                         exp_v[12], exp_v[11], exp_v[10:7], exp_v[6:0]);
            end
        end
    end

    // One clock with the currently driven inputs; model advances alongside.
    task automatic step();
        sb.push_back(expect_out(n_en, val_m, dp_m, blank_lz, enable));
        if (enable) n_en++;
        if (load) begin
            val_m = value;
            dp_m  = dp_in;
        end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic load_step(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp_in = d;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    // Asynchronous reset: pins must go unlit before any clock edge.
    task automatic do_reset(input string name);
        rst = 1'b1;
        #1;
        checks++;
        if ({frame_tick, dp_out, an_out, seg_out} !== {1'b0, 1'b1, 4'hF, 7'h7F}) begin
            errors++;
            $display("FAIL %s: got ft=%b dp=%b an=%b seg=%h, expected ft=0 dp=1 an=1111 seg=7f",
                     name, frame_tick, dp_out, an_out, seg_out);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        rst   = 1'b0;
        n_en  = 0;
        val_m = '0;
        dp_m  = '0;
    endtask

    initial begin
        rst      = 1'b1;
        value    = '0;
        dp_in    = '0;
        load     = 1'b0;
        blank_lz = 1'b0;
        enable   = 1'b0;
        n_en     = 0;
        val_m    = '0;
        dp_m     = '0;

        do_reset("reset_initial");
        run(3);

        // Plain scan of 12AF across several frames.
        enable = 1'b1;
        load_step(16'h12AF, 4'b0000);
        run(41);

        // Abort mid-scan, then restart from digit 0.
        do_reset("reset_midscan");
        load_step(16'h12AF, 4'b0000);
        run(20);

        // Leading-zero suppression.
        blank_lz = 1'b1;
        load_step(16'h0030, 4'b0000);
        run(20);
        load_step(16'h0000, 4'b0000);
        run(20);

        // Decimal point on a blanked digit.
        load_step(16'h0005, 4'b0100);
        run(20);

        // Enable gating in the middle of digit 2's dwell.
        do_reset("reset_before_gate");
        blank_lz = 1'b0;
        load_step(16'h12AF, 4'b0000);
        run(8);
        enable = 1'b0;
        run(10);
        enable = 1'b1;
        run(20);

        // Load coinciding with a scan tick.
        for (int i = 0; i < SCAN_DIV && (n_en % SCAN_DIV) != SCAN_DIV - 1; i++) step();
        load_step(16'hFFFF, 4'b1010);
        run(20);

        // Randomized traffic, with one reset in the middle.
        for (int i = 0; i < 600; i++) begin
            enable   = ($urandom_range(0, 7) != 0);
            load     = ($urandom_range(0, 3) == 0);
            blank_lz = $urandom_range(0, 1) != 0;
            value    = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            dp_in    = 4'($urandom);
            step();
            if (i == 300) begin
                load = 1'b0;
                do_reset("reset_random");
            end
        end
        load = 1'b0;

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digits; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000: clocks per digit dwell; legal range >= 2.
REQ-003 Parameter ACTIVE_LOW, default 1: 1 = segment, dp and anode outputs are driven 0 when lit; 0 = driven 1 when lit.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 value  input  4*DIGITS  hex nibbles; digit k = value[4k+3:4k]; digit 0 is rightmost/LSB.
REQ-007 dp_in  input  DIGITS  decimal point request per digit.
REQ-008 load  input  1  capture value and dp_in into shadow registers on this edge.
REQ-009 blank_lz  input  1  enable leading-zero suppression.
REQ-010 enable  input  1  scan and display enable.
REQ-011 seg_out  output  7  segments {g,f,e,d,c,b,a}, registered.
REQ-012 dp_out  output  1  decimal point, registered.
REQ-013 an_out  output  DIGITS  digit select, one-hot when lit, registered.
REQ-014 frame_tick  output  1  one-cycle pulse at end of each full scan frame, registered.

Function
REQ-015 Shadow registers value_q and dp_q SHALL load value and dp_in on any edge with load=1 and hold otherwise, independent of enable.
REQ-016 Prescaler SHALL count 0..SCAN_DIV-1 while enable=1, wrapping to 0 after SCAN_DIV-1; the wrap cycle is the scan tick.
REQ-017 Digit index SHALL advance by 1 on each scan tick, wrapping DIGITS-1 -> 0; frame_tick SHALL pulse for exactly the cycle after the wrap tick.
REQ-018 With enable=0, prescaler and index SHALL hold, frame_tick SHALL be 0, and all outputs SHALL be driven to the unlit level.
REQ-019 Outputs SHALL be registered from current (index, value_q, dp_q, blank_lz, enable): latency 1 cycle from any change in these; load -> visible output after 2 edges.
REQ-020 Active-low nibble-to-segment map 0..F SHALL be hex 40,79,24,30,19,12,02,78,00,18,08,03,46,21,06,0E; ACTIVE_LOW=0 outputs the bitwise inverse.
REQ-021 an_out SHALL light only the bit equal to the index; all other anodes unlit.
REQ-022 With blank_lz=1, digit k SHALL be blanked (all segments unlit) when nibble k and all higher nibbles are 0; digit 0 SHALL never be blanked.
REQ-023 dp_out SHALL follow dp_q[index] including on blanked digits.
REQ-024 Simultaneous load and scan tick: index advance and shadow capture both take effect on the same edge.
REQ-025 enable rising: scan SHALL resume from the held index and prescaler count, no reset of position.

Reset
REQ-026 rst=1 SHALL, asynchronously, clear value_q, dp_q, prescaler, index to 0, frame_tick to 0, and drive seg_out, dp_out, an_out to unlit level.
REQ-027 Reset asserted mid-frame SHALL abort the scan; after release, the first lit digit SHALL be digit 0 with a full SCAN_DIV dwell.

Verification (DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1)
REQ-028 Reset: assert rst mid-scan -> an_out=1111, seg_out=7F, dp_out=1, frame_tick=0 immediately without clock edge.
REQ-029 Scan: load value=16'h12AF, dp_in=0000, enable=1 -> an_out cycles 1110,1101,1011,0111 each for 4 clocks with seg_out 0E,08,24,79; frame_tick one pulse per 16 clocks.
REQ-030 Leading zeros: value=16'h0030, blank_lz=1 -> digits 3,2 seg_out=7F, digit 1 seg_out=30, digit 0 seg_out=40; value=16'h0000 -> only digit 0 shows 40.
REQ-031 Decimal point: dp_in=0100, value=16'h0005, blank_lz=1 -> digit 2 seg_out=7F with dp_out=0; other digits dp_out=1.
REQ-032 Enable gating: drop enable for 10 clocks mid-dwell of digit 2 -> outputs unlit 1 cycle later, no frame_tick; re-enable resumes digit 2 for the remaining dwell count.
REQ-033 Load/tick collision: load value=16'hFFFF on a scan-tick edge -> next digit shows 0E two edges after load, no skipped or repeated digit.
